fir_serial_mac: RTL and testbench
=================================

# fir_serial_mac

Time-multiplexed FIR tap engine. It is the stage directly downstream of the 16-bit sample delay registers: it holds a TAPS-deep delay line of 16-bit samples and computes one output per accepted input sample. It uses a single multiplier-accumulator that iterates over the taps, one tap per cycle. Samples arrive on a valid/ready input handshake, results leave on a valid/ready output handshake, and coefficients are loaded through a simple write port.

## Interface
- TAPS, 8: number of taps. Must be ≥2.
- DATA_W, 16: sample width, signed two's complement.
- COEF_W, 16: coefficient width, signed two's complement.
- SHIFT, 15: right shift applied to the accumulator before output (Q15 coefficients).
- ACC_W, DATA_W+COEF_W+$clog2(TAPS): accumulator width. No internal overflow is possible.
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset. Clears all state immediately.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a sample. High only in IDLE.
- in_data  in  DATA_W  input sample.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  downstream accepts the result.
- out_data  out  DATA_W  rounded, saturated filter output.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  coefficient index k.
- coef_wdata  in  COEF_W  coefficient value c[k].

## Operation
- Storage:
  - Delay line x[0..TAPS-1], DATA_W each.
  - Coefficient bank c[0..TAPS-1].
  - Accumulator acc (ACC_W).
  - Tap index idx.
  - 2-bit state register.
- Reset values:
  - All x, all c, acc, idx and out_data are 0.
  - State is IDLE, so in_ready=1 and out_valid=0.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: x[0]<=in_data, x[k]<=x[k-1] for k≥1; acc<=0; idx<=0; next state MAC.
- MAC:
  - Each cycle: acc<=acc + x[idx]*c[idx] (signed full-precision product, sign-extended to ACC_W); idx<=idx+1.
  - On the cycle where idx==TAPS-1: compute the final sum S = acc + x[TAPS-1]*c[TAPS-1] and register out_data<=sat(round(S)); next state OUT.
  - in_ready=0.
- OUT:
  - out_valid=1; out_data is held stable.
  - On out_ready: next state IDLE.
  - in_ready=0.
- Rounding: round(S) = (S + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift. Ties therefore round toward +∞ (for example, -0.5 becomes 0). When SHIFT=0, no bias is added.
- Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Coefficient writes:
  - coef_we is honoured only in IDLE: c[coef_addr]<=coef_wdata.
  - In MAC or OUT, coef_we is ignored and dropped, not queued.
  - A write and a sample accept in the same IDLE cycle both take effect. The new coefficient is used for that sample.
- in_valid while in MAC or OUT: nothing happens. The upstream stage holds in_data until in_ready.
- reset_n low in any state, including mid-MAC or during an OUT stall:
  - Immediately clears all state, including the delay line and coefficients.
  - The partial result is discarded and never emitted.

## Timing
- Accept edge E0 is the rising edge where in_valid&&in_ready.
- MAC edges are E1..E_TAPS. out_data and out_valid are registered at E_TAPS.
- Latency: out_valid is high in the cycle after E_TAPS, i.e. TAPS edges after the accept edge.
- Output handshake: completes at the first edge with out_valid&&out_ready. out_valid is low after that edge.
- Minimum sample period: TAPS+2 edges (TAPS MAC, 1 OUT, 1 IDLE). This gives 10 at TAPS=8.
- Backpressure: while out_ready=0, state remains OUT indefinitely. out_data and out_valid are stable and in_ready=0.
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Test plan
All scenarios use TAPS=8 and SHIFT=15.
- Reset:
  - Stimulus: assert reset_n=0 asynchronously mid-cycle.
  - Required response: out_valid=0, out_data=0 and in_ready=1 immediately and while held. After release, the first output with all coefficients at 0 is 0.
- Impulse response:
  - Stimulus: load c[k]=1000*(k+1). Feed 16384, then seven 0 samples, then two more 0 samples; out_ready=1.
  - Required response: outputs 500, 1000, 1500, 2000, 2500, 3000, 3500, 4000, then 0, 0.
- Saturation:
  - Stimulus A: all c=32767; feed eight samples of 32767.
  - Required response A: 8th output is 32767.
  - Stimulus B: then feed eight samples of -32768.
  - Required response B: output is -32768 once the delay line is full of -32768.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises, with in_valid=1 throughout.
  - Required response: out_data stable, in_ready=0 and no new sample taken. The next accept occurs exactly 1 edge after the out handshake.
- Coefficient write in MAC:
  - Stimulus: pulse coef_we to c[0]=0x7FFF while in MAC.
  - Required response: the current and subsequent results are unchanged versus the golden model; c[0] keeps its old value.
- Mid-MAC reset:
  - Stimulus: reset_n low for 1 cycle at E3 of a computation.
  - Required response: no out_valid from that sample.
- Throughput:
  - Stimulus: in_valid and out_ready held high, random data.
  - Required response: accepts every 10 cycles; out_valid exactly 8 edges after each accept; results match the bit-exact reference model.

Source files
------------

// File: rtl/fir_serial_mac.sv
// fir_serial_mac: time-multiplexed FIR tap engine with one shared multiplier-accumulator
module fir_serial_mac #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int SHIFT  = 15,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_W-1:0]       out_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [COEF_W-1:0]       coef_wdata
);
    localparam int IW = $clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;
    localparam logic signed [ACC_W:0] BIAS = ((ACC_W+1)'(1) << SHIFT) >> 1;
    localparam logic signed [ACC_W:0] MAXV = (ACC_W+1)'(2**(DATA_W-1) - 1);
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                   state, state_nxt;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] c [TAPS];
    logic signed [ACC_W-1:0]  acc, sum;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W:0]    biased, scaled;
    logic [DATA_W-1:0]        sat_val;
    logic [IW-1:0]            idx;
    logic                     accept, in_mac, last;

    assign accept  = in_valid && in_ready;
    assign in_mac  = state == MAC;
    assign last    = in_mac && idx == IW'(TAPS-1);
    assign prod    = x[idx] * c[idx];
    assign sum     = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
    assign biased  = {sum[ACC_W-1], sum} + BIAS;
    assign scaled  = biased >>> SHIFT;
    assign sat_val = scaled > MAXV ? MAXV[DATA_W-1:0] :
                     scaled < MINV ? MINV[DATA_W-1:0] : scaled[DATA_W-1:0];

    // state register
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;

    // next state and handshake outputs, decoded from registered state only
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = MAC;
            end
            MAC: if (last) state_nxt = OUT;
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // sample delay line, shifted once per accepted sample
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) x[k] <= '0;
        end else if (accept) begin
            x[0] <= in_data;
            for (int k = 1; k < TAPS; k++) x[k] <= x[k-1];
        end

    // coefficient bank, writable only while idle; writes in other states are dropped
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int k = 0; k < TAPS; k++) c[k] <= '0;
        end else if (coef_we && state == IDLE) begin
            c[coef_addr] <= coef_wdata;
        end

    // accumulator and tap index, one tap per MAC cycle
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            acc <= '0;
            idx <= '0;
        end else if (accept) begin
            acc <= '0;
            idx <= '0;
        end else if (in_mac) begin
            acc <= sum;
            idx <= idx + 1'b1;
        end

    // result register, loaded with the rounded and saturated final sum on the last tap
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n)
            out_data <= '0;
        else if (last)
            out_data <= sat_val;
endmodule

// File: tb/tb_fir_serial_mac.sv
// tb_fir_serial_mac: randomized bench comparing the FIR engine against a behavioural model
`timescale 1ns/1ps
module tb_fir_serial_mac;
    localparam int TAPS  = 8;
    localparam int SHIFT = 15;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, coef_we = 1'b0;
    logic [15:0] in_data = '0, out_data, coef_wdata = '0;
    logic [2:0]  coef_addr = '0;
    int          n_tests = 0, n_fail = 0;
    longint      cm [TAPS];
    longint      xm [TAPS];
    time         t_hs = 0, last_acc = 0;

    always #5 clk = ~clk;

    fir_serial_mac #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_out();
        longint s = 0;
        longint r;
        for (int k = 0; k < TAPS; k++) s += xm[k] * cm[k];
        r = (s + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > 32767) r = 32767;
        else if (r < -32768) r = -32768;
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            cm[k] = 0;
            xm[k] = 0;
        end
    endtask

    task automatic write_coef(input int k, input logic signed [15:0] v);
        coef_we = 1'b1;
        coef_addr = 3'(k);
        coef_wdata = v;
        @(posedge clk);
        #1 coef_we = 1'b0;
        cm[k] = v;
    endtask

    // gap: 0 no timing check, 1 accept one edge after last handshake, 2 also 10-edge period
    task automatic run_sample(input logic signed [15:0] d, input int stall,
                              input logic [15:0] nxt, input bit mac_wr, input int gap,
                              output longint got);
        int n;
        time t_acc;
        longint exp;
        in_valid = 1'b1;
        in_data = d;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("ready_wait", n < 40, 1);
        @(posedge clk);
        t_acc = $time;
        #1;
        if (gap > 0) check("accept_gap", t_acc - t_hs, 10);
        if (gap > 1) check("period", t_acc - last_acc, 100);
        last_acc = t_acc;
        if (stall > 0) in_data = nxt;
        else if (gap == 0) in_valid = 1'b0;
        for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = d;
        exp = model_out();
        if (mac_wr) begin
            coef_we = 1'b1;
            coef_addr = 3'd0;
            coef_wdata = 16'h7fff;
        end
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 coef_we = 1'b0;
            n++;
        end
        check("latency", n, TAPS);
        got = $signed(out_data);
        check("out_data", got, exp);
        repeat (stall) begin
            @(posedge clk);
            #1;
            check("bp_valid", out_valid, 1);
            check("bp_ready", in_ready, 0);
            check("bp_hold", $signed(out_data), got);
        end
        out_ready = 1'b1;
        @(posedge clk);
        t_hs = $time;
        #1;
        check("hs_valid", out_valid, 0);
    endtask

    initial begin
        longint got;
        logic signed [15:0] r;
        int n;
        bit seen;
        model_reset();
        #13;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk);
        #1;
        r = 16'($urandom);
        run_sample(r, 0, 16'd0, 1'b0, 0, got);
        check("zero_coef_out", got, 0);
        for (int i = 0; i < TAPS; i++) run_sample(16'sd0, 0, 16'd0, 1'b0, 0, got);

        for (int k = 0; k < TAPS; k++) write_coef(k, 16'(1000 * (k + 1)));
        for (int i = 0; i < 10; i++) begin
            run_sample(i == 0 ? 16'sd16384 : 16'sd0, 0, 16'd0, 1'b0, 0, got);
            check("impulse", got, i < 8 ? 500 * (i + 1) : 0);
        end

        for (int k = 0; k < TAPS; k++) write_coef(k, 16'sd32767);
        for (int i = 0; i < TAPS; i++) run_sample(16'sd32767, 0, 16'd0, 1'b0, 0, got);
        check("sat_pos", got, 32767);
        for (int i = 0; i < TAPS; i++) run_sample(16'sh8000, 0, 16'd0, 1'b0, 0, got);
        check("sat_neg", got, -32768);

        for (int k = 0; k < TAPS; k++) write_coef(k, 16'($urandom));
        for (int i = 0; i < 4; i++) run_sample(16'($urandom), 0, 16'd0, 1'b0, 0, got);
        r = 16'($urandom);
        out_ready = 1'b0;
        run_sample(16'($urandom), 5, r, 1'b0, 0, got);
        run_sample(r, 0, 16'd0, 1'b0, 1, got);
        in_valid = 1'b0;

        run_sample(16'($urandom), 0, 16'd0, 1'b1, 0, got);
        for (int i = 0; i < 3; i++) run_sample(16'($urandom), 0, 16'd0, 1'b0, 0, got);

        for (int i = 0; i < 20; i++) run_sample(16'($urandom), 0, 16'd0, 1'b0, i == 0 ? 1 : 2, got);
        in_valid = 1'b0;

        in_valid = 1'b1;
        in_data = 16'($urandom);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        @(posedge clk);
        #2 reset_n = 1'b1;
        model_reset();
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1 seen |= out_valid;
        end
        check("mid_rst_no_out", seen, 0);

        for (int k = 0; k < TAPS; k++) write_coef(k, 16'($urandom));
        for (int i = 0; i < TAPS; i++) run_sample(16'($urandom), 0, 16'd0, 1'b0, 0, got);
        out_ready = 1'b0;
        in_valid = 1'b1;
        r = 16'($urandom);
        in_data = r;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
        xm[0] = r;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        check("stall_latency", n, TAPS);
        check("stall_data", $signed(out_data), model_out());
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_data", out_data, 0);
        check("async_rst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        #1;
        check("held_rst_valid", out_valid, 0);
        check("held_rst_ready", in_ready, 1);
        #3 reset_n = 1'b1;
        model_reset();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        run_sample(16'($urandom), 0, 16'd0, 1'b0, 0, got);
        check("post_rst_zero", got, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
